// File: rtl/pipe_pkg.sv
// Shared fetch-stage types and constants for the PC fetch unit.
package pipe_pkg;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} fetch_state_t;

    localparam int          PC_INC     = 4;
    localparam logic [31:0] ALIGN_MASK = 32'h3;

endpackage

// File: rtl/pc_fetch_unit_flush_timer.sv
// Loadable down-counter that sizes the post-redirect flush window; done when it reaches zero.
module flush_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register with stall hold, redirect load and a timed post-redirect flush.
// Optional redirect counter enabled by defining PC_REDIRECT_CNT_EN.
module pc_fetch_unit
    import pipe_pkg::*;
#(
    parameter int              PC_W         = 9,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic [PC_W-1:0] Cur_PC,
    output logic            if_valid,
    output logic            flush,
    output logic            misalign_err
`ifdef PC_REDIRECT_CNT_EN
    ,output logic [31:0]    redirect_cnt
`endif
);

    fetch_state_t    r_state, w_next_state;
    logic [PC_W-1:0] r_pc, w_next_pc, w_pc_inc;
    logic            r_misalign;
    logic            w_accept, w_misalign, w_timer_done;

    assign w_pc_inc = r_pc + PC_W'(PC_INC);

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_accept     = 1'b0;
        w_misalign   = 1'b0;
        case (r_state)
            S_BOOT: w_next_state = S_RUN;
            S_RUN: begin
                // A redirect beats the stall; a misaligned one falls back to normal sequencing.
                if (PcSel && (BrPC & ALIGN_MASK) == 32'h0) begin
                    w_accept     = 1'b1;
                    w_next_pc    = BrPC[PC_W-1:0];
                    w_next_state = S_FLUSH;
                end else begin
                    w_misalign = PcSel;
                    if (!stall) w_next_pc = w_pc_inc;
                end
            end
            S_FLUSH: begin
                if (!stall)       w_next_pc    = w_pc_inc;
                if (w_timer_done) w_next_state = S_RUN;
            end
            default: w_next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_misalign <= r_misalign | w_misalign;
        end
    end

    flush_timer #(.W(3)) u_flush_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_val  (3'(FLUSH_CYCLES - 1)),
        .i_en   (r_state == S_FLUSH),
        .o_done (w_timer_done)
    );

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_redirect_cnt <= '0;
        else if (w_accept)
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end

    assign redirect_cnt = r_redirect_cnt;
`endif

    assign Cur_PC       = r_pc;
    assign flush        = (r_state == S_FLUSH);
    assign if_valid     = (r_state == S_RUN);
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: cycle-by-cycle model compare plus literal spot checks.
module tb_pc_fetch_unit;

    localparam int PC_W   = 9;
    localparam int FLUSHN = 2;
    localparam int PCMASK = (1 << PC_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall, PcSel;
    logic [31:0]     BrPC;
    logic [PC_W-1:0] Cur_PC;
    logic            if_valid, flush, misalign_err;
`ifdef PC_REDIRECT_CNT_EN
    logic [31:0]     redirect_cnt;
`endif

    pc_fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .FLUSH_CYCLES(FLUSHN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .PcSel        (PcSel),
        .BrPC         (BrPC),
        .Cur_PC       (Cur_PC),
        .if_valid     (if_valid),
        .flush        (flush),
        .misalign_err (misalign_err)
`ifdef PC_REDIRECT_CNT_EN
        ,.redirect_cnt (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miss    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: booting flag, remaining flush cycles, PC as plain modular arithmetic.
    bit          m_boot;
    int          m_pc, m_left;
    bit          m_err;
    logic [31:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot <= 1'b1; m_pc <= 0; m_left <= 0; m_err <= 1'b0; m_cnt <= '0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (m_left == 0 && PcSel && BrPC[1:0] == 2'b00) begin
            m_pc   <= int'(BrPC) & PCMASK;
            m_left <= FLUSHN;
            m_cnt  <= m_cnt + 1;
        end else begin
            if (m_left == 0 && PcSel) m_err <= 1'b1;
            if (!stall) m_pc <= (m_pc + 4) & PCMASK;
            if (m_left > 0) m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        chk("model Cur_PC",   32'(Cur_PC),   32'(m_pc));
        chk("model flush",    32'(flush),    32'(!m_boot && m_left > 0));
        chk("model if_valid", 32'(if_valid), 32'(!m_boot && m_left == 0));
        chk("model misalign", 32'(misalign_err), 32'(m_err));
`ifdef PC_REDIRECT_CNT_EN
        chk("model redirect_cnt", redirect_cnt, m_cnt);
`endif
    end

    task automatic tick(); @(posedge clk); #2; endtask
    task automatic peek(); @(negedge clk); #1; endtask

    task automatic wait_pc(input logic [PC_W-1:0] target, input string nm);
        int n = 0;
        while (Cur_PC !== target && n < 300) begin tick(); n++; end
        if (n >= 300) chk({nm, " timeout"}, 32'(Cur_PC), 32'(target));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; PcSel = 1'b0; BrPC = '0;
        #12;
        chk("rst Cur_PC", 32'(Cur_PC), 32'h0);
        chk("rst if_valid", 32'(if_valid), 32'h0);
        chk("rst flush", 32'(flush), 32'h0);
        chk("rst misalign", 32'(misalign_err), 32'h0);
        #4 rst_n = 1'b1;

        // 1: boot cycle, then sequential fetch
        peek(); chk("boot pc", 32'(Cur_PC), 32'h000); chk("boot valid", 32'(if_valid), 32'h0);
        peek(); chk("run pc0", 32'(Cur_PC), 32'h000); chk("run valid", 32'(if_valid), 32'h1);
        peek(); chk("run pc1", 32'(Cur_PC), 32'h004);
        peek(); chk("run pc2", 32'(Cur_PC), 32'h008);

        // 2: wrap at the top of the address space
        wait_pc(9'h1F8, "wait 1F8");
        peek(); chk("pre-wrap", 32'(Cur_PC), 32'h1F8);
        tick(); peek(); chk("wrap 1FC", 32'(Cur_PC), 32'h1FC);
        tick(); peek(); chk("wrap 000", 32'(Cur_PC), 32'h000); chk("wrap flush", 32'(flush), 32'h0);

        // 3: aligned redirect from 0x010
        wait_pc(9'h010, "wait 010");
        PcSel = 1'b1; BrPC = 32'h0000_0040;
        tick(); PcSel = 1'b0;
        peek(); chk("redir pc", 32'(Cur_PC), 32'h040); chk("redir flush1", 32'(flush), 32'h1);
        chk("redir valid", 32'(if_valid), 32'h0);
        tick(); peek(); chk("redir pc+4", 32'(Cur_PC), 32'h044); chk("redir flush2", 32'(flush), 32'h1);
        tick(); peek(); chk("redir pc+8", 32'(Cur_PC), 32'h048); chk("redir done", 32'(flush), 32'h0);
        chk("redir valid2", 32'(if_valid), 32'h1);
`ifdef PC_REDIRECT_CNT_EN
        chk("redir cnt", redirect_cnt, 32'd1);
`endif

        // 4: redirect overrides stall; stall held through flush
        PcSel = 1'b1; stall = 1'b1; BrPC = 32'h0000_0080;
        tick(); PcSel = 1'b0;
        peek(); chk("stall redir pc", 32'(Cur_PC), 32'h080); chk("stall flush1", 32'(flush), 32'h1);
        tick(); peek(); chk("stall hold", 32'(Cur_PC), 32'h080); chk("stall flush2", 32'(flush), 32'h1);
        tick(); peek(); chk("stall hold2", 32'(Cur_PC), 32'h080); chk("stall flush end", 32'(flush), 32'h0);
        stall = 1'b0;

        // 5: misaligned redirect rejected, then PcSel during flush ignored
        PcSel = 1'b1; BrPC = 32'h0000_0042;
        tick(); PcSel = 1'b0;
        peek(); chk("misalign pc", 32'(Cur_PC), 32'h084); chk("misalign err", 32'(misalign_err), 32'h1);
        chk("misalign noflush", 32'(flush), 32'h0);
        PcSel = 1'b1; BrPC = 32'h0000_0100;
        tick(); BrPC = 32'h0000_01C0;
        tick(); PcSel = 1'b0;
        peek(); chk("ignore pc", 32'(Cur_PC), 32'h104); chk("ignore flush", 32'(flush), 32'h1);
        tick(); peek(); chk("ignore pc2", 32'(Cur_PC), 32'h108); chk("err sticky", 32'(misalign_err), 32'h1);
`ifdef PC_REDIRECT_CNT_EN
        chk("cnt after ignore", redirect_cnt, 32'd3);
`endif

        // 6: reset in the first flush cycle
        PcSel = 1'b1; BrPC = 32'hFFFF_FE20;
        tick(); PcSel = 1'b0;
        chk("high-bit redir", 32'(Cur_PC), 32'h020); chk("pre-rst flush", 32'(flush), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("async flush drop", 32'(flush), 32'h0);
        chk("async pc", 32'(Cur_PC), 32'h000); chk("async err clr", 32'(misalign_err), 32'h0);
        tick(); rst_n = 1'b1;
        peek(); chk("post-rst pc", 32'(Cur_PC), 32'h000); chk("post-rst valid", 32'(if_valid), 32'h0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
